// File: rtl/io_uart_gpio_pkg.sv
// io_uart_gpio_pkg: register map, STATUS field positions and UART FSM encodings
package io_uart_gpio_pkg;
  localparam logic [7:0] IO_TXDATA  = 8'h00;
  localparam logic [7:0] IO_STATUS  = 8'h04;
  localparam logic [7:0] IO_BAUDDIV = 8'h08;
  localparam logic [7:0] IO_GPIOOUT = 8'h0C;
  localparam logic [7:0] IO_GPIOIN  = 8'h10;
  localparam logic [7:0] IO_CYCLE   = 8'h14;
  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  function automatic logic sel(input logic [7:0] addr, input logic [7:0] off);
    return addr[7:2] == off[7:2];
  endfunction
endpackage

// File: rtl/io_uart_gpio_sync_fifo.sv
// io_uart_gpio_sync_fifo: first-word-fall-through FIFO feeding the UART transmitter
module io_uart_gpio_sync_fifo #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_DEPTH_LOG = 2,
  parameter int WIDTH          = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [WIDTH-1:0]          din_i,
  output logic [WIDTH-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [FIFO_DEPTH_LOG:0]   count_o
);
  localparam int CW = FIFO_DEPTH_LOG + 1;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  // storage needs no reset: only slots between the pointers are ever observed
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wr_q] <= din_i;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + FIFO_DEPTH_LOG'(1);
      if (pop_i) rd_q <= rd_q + FIFO_DEPTH_LOG'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/io_uart_gpio.sv
// io_uart_gpio: UART transmitter, GPIO and cycle counter on the I/O window
module io_uart_gpio
  import io_uart_gpio_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          FIFO_DEPTH_LOG = 2,
  parameter logic [15:0] BAUDDIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        uart_tx
);
  logic [1:0] state_q, state_d;
  logic [15:0] bcnt_q, bcnt_d, baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, gpio_q, gpio_d, sync1_q, sync2_q, fifo_dout;
  logic tx_q, tx_d, ovf_q, ovf_d;
  logic [31:0] cyc_q, status, rdata;
  logic [FIFO_DEPTH_LOG:0] fifo_cnt;
  logic fifo_full, fifo_empty, pop, push, wr, wr_tx, wr_st;
  logic unused_ok;
  assign wr       = io_en & io_we;
  assign wr_tx    = wr & sel(io_addr, IO_TXDATA);
  assign wr_st    = wr & sel(io_addr, IO_STATUS);
  assign pop      = (state_q == S_IDLE) & ~fifo_empty;
  assign push     = wr_tx & (~fifo_full | pop);
  assign ovf_d    = (ovf_q & ~(wr_st & io_data_write[ST_OVF])) | (wr_tx & fifo_full & ~pop);
  assign baud_d   = (wr & sel(io_addr, IO_BAUDDIV)) ? io_data_write[15:0] : baud_q;
  assign gpio_d   = (wr & sel(io_addr, IO_GPIOOUT)) ? io_data_write[7:0] : gpio_q;
  assign gpio_out = gpio_q;
  assign uart_tx  = tx_q;
  assign unused_ok = ^{io_addr[1:0], io_data_write[31:16]};
  io_uart_gpio_sync_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_DEPTH_LOG(FIFO_DEPTH_LOG),
    .WIDTH(8)
  ) u_fifo (
    .clk_i(clk),
    .rst_ni(resetb),
    .push_i(push),
    .pop_i(pop),
    .din_i(io_data_write[7:0]),
    .dout_o(fifo_dout),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );
  // 8N1 framing: every bit holds for BAUDDIV+1 cycles, reloading the divisor at each bit boundary
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q == S_IDLE) begin
      if (pop) begin
        state_d = S_START;
        bcnt_d  = baud_q;
        shift_d = fifo_dout;
        tx_d    = 1'b0;
      end
    end else if (bcnt_q != '0) bcnt_d = bcnt_q - 16'd1;
    else begin
      bcnt_d = baud_q;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
        S_DATA:
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // zero-latency read mux; the bus only samples it while io_en is high
  always_comb begin
    status                 = '0;
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_BUSY]        = state_q != S_IDLE;
    status[ST_OVF]         = ovf_q;
    status[ST_CNT +: 5]    = 5'(fifo_cnt);
    case (io_addr[7:2])
      IO_STATUS[7:2]:  rdata = status;
      IO_BAUDDIV[7:2]: rdata = {16'd0, baud_q};
      IO_GPIOOUT[7:2]: rdata = {24'd0, gpio_q};
      IO_GPIOIN[7:2]:  rdata = {24'd0, sync2_q};
      IO_CYCLE[7:2]:   rdata = cyc_q;
      default:         rdata = '0;
    endcase
    io_data_read = io_en ? rdata : '0;
  end
  // architectural state; reset drives the line idle without waiting for a clock
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      baud_q  <= BAUDDIV_RESET;
      gpio_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      baud_q  <= baud_d;
      gpio_q  <= gpio_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      cyc_q   <= cyc_q + 32'd1;
    end
endmodule
